// File: rtl/servo_ctrl.sv
// Hobby-servo position controller: turns angle commands into a PWM duty/period
// pair, slewing the duty toward the commanded width by at most STEP per frame.
// The frame counter mirrors the PWM instance's counter so duty changes land
// exactly on frame boundaries.
module servo_ctrl #(
  parameter int unsigned PERIOD_CYCLES = 500000,
  parameter int unsigned MIN_PULSE     = 25000,
  parameter int unsigned DEG_CYCLES    = 139,
  parameter int unsigned STEP          = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_angle,
  output logic        cmd_ready,
  output logic [31:0] duty_cycle,
  output logic [31:0] period,
  output logic        pwm_rst_n,
  output logic        frame_tick,
  output logic        busy,
  output logic        at_target
);

  localparam logic [31:0] PERIOD_W = 32'(PERIOD_CYCLES);
  localparam logic [31:0] MIN_W    = 32'(MIN_PULSE);
  localparam logic [31:0] DEG_W    = 32'(DEG_CYCLES);
  localparam logic [31:0] STEP_W   = 32'(STEP);
  localparam logic [31:0] TGT_RST  = 32'(MIN_PULSE + 90 * DEG_CYCLES);

  typedef enum logic [1:0] {S_OFF, S_HOLD, S_SLEW} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] duty_q, duty_d;
  logic [31:0] target_q, target_d;
  logic        tick_d, ready_d, busy_d, at_d;

  logic [7:0]  ang_c;
  logic [31:0] cmd_tgt, up_gap, dn_gap, stepped;
  logic        accept, wrap;

  assign period = PERIOD_W;

  assign ang_c   = (cmd_angle > 8'd180) ? 8'd180 : cmd_angle;
  assign cmd_tgt = MIN_W + 32'(ang_c) * DEG_W;
  // cmd_ready is registered and already implies a non-OFF state
  assign accept  = cmd_valid & cmd_ready;
  assign wrap    = (cnt_q == PERIOD_W - 32'd1);

  // One frame step toward the target currently held (not a same-edge command)
  assign up_gap  = target_q - duty_q;
  assign dn_gap  = duty_q - target_q;
  assign stepped = (target_q >= duty_q) ? duty_q + ((up_gap > STEP_W) ? STEP_W : up_gap)
                                        : duty_q - ((dn_gap > STEP_W) ? STEP_W : dn_gap);

  // Next-state and next-output computation; state follows duty/target equality
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    target_d = accept ? cmd_tgt : target_q;
    tick_d   = 1'b0;
    if (state_q == S_OFF) begin
      cnt_d  = 32'd0;
      duty_d = 32'd0;
      if (enable) begin
        state_d = S_HOLD;
        duty_d  = target_q;
      end
    end else if (!enable) begin
      state_d = S_OFF;
      cnt_d   = 32'd0;
      duty_d  = 32'd0;
    end else begin
      cnt_d  = wrap ? 32'd0 : cnt_q + 32'd1;
      tick_d = wrap;
      if (wrap && state_q == S_SLEW) duty_d = stepped;
      state_d = (duty_d != target_d) ? S_SLEW : S_HOLD;
    end
    ready_d = (state_d != S_OFF);
    busy_d  = ready_d && (duty_d != target_d);
    at_d    = ready_d && (duty_d == target_d);
  end

  // FSM state, frame counter and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      cnt_q      <= 32'd0;
      duty_q     <= 32'd0;
      target_q   <= TGT_RST;
      frame_tick <= 1'b0;
      cmd_ready  <= 1'b0;
      pwm_rst_n  <= 1'b0;
      busy       <= 1'b0;
      at_target  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      frame_tick <= tick_d;
      cmd_ready  <= ready_d;
      pwm_rst_n  <= ready_d;
      busy       <= busy_d;
      at_target  <= at_d;
    end
  end

  assign duty_cycle = duty_q;

endmodule
